// File: rtl/instr_reg_if.sv
// Controller/memory-side bundle for the instruction register.
// The master drives the strobes and data bus. The slave returns the decoded fields and fetch status.
interface instr_reg_if #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 3,
  parameter int CNT_W  = 8
);
  localparam int ADDR_W = 2*DATA_W - OPC_W;

  logic              ena;
  logic              load_ir;
  logic [DATA_W-1:0] data;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              instr_valid;
  logic              byte_phase;
  logic              fetch_done;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    output ena, load_ir, data,
    input  opcode, ir_addr, instr_valid, byte_phase, fetch_done, fetch_cnt
  );

  modport slave (
    input  ena, load_ir, data,
    output opcode, ir_addr, instr_valid, byte_phase, fetch_done, fetch_cnt
  );
endinterface

// File: rtl/instr_reg.sv
// Instruction register: builds {opcode, ir_addr} from two byte loads. IR_SHADOW_EN buffers the high byte so the fields update atomically.
// Fields are visible one cycle after the low-byte load. There is no backpressure: every sampled load_ir is accepted.
module instr_reg #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  instr_reg_if.slave  bus
);
  localparam int ADDR_W = 2*DATA_W - OPC_W;

  typedef enum logic {PH_HI = 1'b0, PH_LO = 1'b1} phase_e;

  phase_e            phase_q, phase_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_done_q, fetch_done_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
`ifdef IR_SHADOW_EN
  logic [DATA_W-1:0] hi_buf_q, hi_buf_d;
`endif

  always_comb begin
    phase_d       = phase_q;
    opcode_d      = opcode_q;
    ir_addr_d     = ir_addr_q;
    instr_valid_d = instr_valid_q;
    fetch_done_d  = 1'b0;
    fetch_cnt_d   = fetch_cnt_q;
`ifdef IR_SHADOW_EN
    hi_buf_d      = hi_buf_q;
`endif
    if (!bus.ena) begin
      // Run-enable drop discards any partial fetch but keeps the fetch count.
      phase_d       = PH_HI;
      opcode_d      = '0;
      ir_addr_d     = '0;
      instr_valid_d = 1'b0;
`ifdef IR_SHADOW_EN
      hi_buf_d      = '0;
`endif
    end else if (bus.load_ir) begin
      if (phase_q == PH_HI) begin
`ifdef IR_SHADOW_EN
        hi_buf_d = bus.data;
`else
        {opcode_d, ir_addr_d[ADDR_W-1:DATA_W]} = bus.data;
        instr_valid_d = 1'b0;
`endif
        phase_d = PH_LO;
      end else begin
`ifdef IR_SHADOW_EN
        {opcode_d, ir_addr_d} = {hi_buf_q, bus.data};
`else
        ir_addr_d[DATA_W-1:0] = bus.data;
`endif
        instr_valid_d = 1'b1;
        fetch_done_d  = 1'b1;
        fetch_cnt_d   = fetch_cnt_q + CNT_W'(1);
        phase_d       = PH_HI;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= PH_HI;
      opcode_q      <= '0;
      ir_addr_q     <= '0;
      instr_valid_q <= 1'b0;
      fetch_done_q  <= 1'b0;
      fetch_cnt_q   <= '0;
`ifdef IR_SHADOW_EN
      hi_buf_q      <= '0;
`endif
    end else begin
      phase_q       <= phase_d;
      opcode_q      <= opcode_d;
      ir_addr_q     <= ir_addr_d;
      instr_valid_q <= instr_valid_d;
      fetch_done_q  <= fetch_done_d;
      fetch_cnt_q   <= fetch_cnt_d;
`ifdef IR_SHADOW_EN
      hi_buf_q      <= hi_buf_d;
`endif
    end
  end

  assign bus.opcode      = opcode_q;
  assign bus.ir_addr     = ir_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.byte_phase  = (phase_q == PH_LO);
  assign bus.fetch_done  = fetch_done_q;
  assign bus.fetch_cnt   = fetch_cnt_q;
endmodule

// File: tb/tb_instr_reg.sv
// Bench for instr_reg: directed vector table, then back-to-back fetches, idle X data and random traffic.
// The random traffic is checked against a byte-count/instruction-word model.
module tb_instr_reg;
  logic clk;
  logic reset;

  instr_reg_if #(.DATA_W(8), .OPC_W(3), .CNT_W(8)) bus ();

  instr_reg #(.DATA_W(8), .OPC_W(3), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: bytes loaded since last clear (mod 2), the pending high byte,
  // and the 16-bit word the fields currently show.
  int m_ph, m_hi, m_word, m_valid, m_done, m_cnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit e, bit l, logic [7:0] d);
    m_done = 0;
    if (r) begin
      m_ph = 0; m_hi = 0; m_word = 0; m_valid = 0; m_cnt = 0;
    end else if (!e) begin
      m_ph = 0; m_hi = 0; m_word = 0; m_valid = 0;
    end else if (l) begin
      if (m_ph == 0) begin
        m_hi = int'(d);
        m_ph = 1;
`ifndef IR_SHADOW_EN
        m_word  = m_hi * 256 + (m_word % 256);
        m_valid = 0;
`endif
      end else begin
        m_word  = m_hi * 256 + int'(d);
        m_valid = 1;
        m_done  = 1;
        m_cnt   = (m_cnt + 1) % 256;
        m_ph    = 0;
      end
    end
  endtask

  task automatic cycle(bit r, bit e, bit l, logic [7:0] d);
    reset       = r;
    bus.ena     = e;
    bus.load_ir = l;
    bus.data    = d;
    @(posedge clk);
    model_step(r, e, l, d);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".opcode"},  32'(bus.opcode),      32'(m_word / 8192));
    chk({tag, ".ir_addr"}, 32'(bus.ir_addr),     32'(m_word % 8192));
    chk({tag, ".valid"},   32'(bus.instr_valid), 32'(m_valid));
    chk({tag, ".phase"},   32'(bus.byte_phase),  32'(m_ph));
    chk({tag, ".done"},    32'(bus.fetch_done),  32'(m_done));
    chk({tag, ".cnt"},     32'(bus.fetch_cnt),   32'(m_cnt));
  endtask

  typedef struct {
    bit         r, e, l;
    logic [7:0] d;
    bit [2:0]   opc;
    bit [12:0]  addr;
    bit         vld, ph, done;
    bit [7:0]   cnt;
  } vec_t;

  vec_t vecs[11];
  int   pulses;
  bit   r, e, l;

  initial begin
    //          r  e  l  data    opc    addr      vld ph done cnt
    vecs[0]  = '{1, 1, 1, 8'hFF, 3'd0, 13'h0000, 0, 0, 0, 8'd0};
    vecs[1]  = '{1, 1, 1, 8'hFF, 3'd0, 13'h0000, 0, 0, 0, 8'd0};
`ifdef IR_SHADOW_EN
    vecs[2]  = '{0, 1, 1, 8'hB2, 3'd0, 13'h0000, 0, 1, 0, 8'd0};
`else
    vecs[2]  = '{0, 1, 1, 8'hB2, 3'd5, 13'h1200, 0, 1, 0, 8'd0};
`endif
    vecs[3]  = '{0, 1, 1, 8'h34, 3'd5, 13'h1234, 1, 0, 1, 8'd1};
    vecs[4]  = '{0, 1, 0, 8'hxx, 3'd5, 13'h1234, 1, 0, 0, 8'd1};
`ifdef IR_SHADOW_EN
    vecs[5]  = '{0, 1, 1, 8'hE0, 3'd5, 13'h1234, 1, 1, 0, 8'd1};
`else
    vecs[5]  = '{0, 1, 1, 8'hE0, 3'd7, 13'h0034, 0, 1, 0, 8'd1};
`endif
    vecs[6]  = '{0, 1, 1, 8'h05, 3'd7, 13'h0005, 1, 0, 1, 8'd2};
`ifdef IR_SHADOW_EN
    vecs[7]  = '{0, 1, 1, 8'h40, 3'd7, 13'h0005, 1, 1, 0, 8'd2};
`else
    vecs[7]  = '{0, 1, 1, 8'h40, 3'd2, 13'h0005, 0, 1, 0, 8'd2};
`endif
    vecs[8]  = '{0, 0, 1, 8'h99, 3'd0, 13'h0000, 0, 0, 0, 8'd2};
`ifdef IR_SHADOW_EN
    vecs[9]  = '{0, 1, 1, 8'h20, 3'd0, 13'h0000, 0, 1, 0, 8'd2};
`else
    vecs[9]  = '{0, 1, 1, 8'h20, 3'd1, 13'h0000, 0, 1, 0, 8'd2};
`endif
    vecs[10] = '{0, 1, 1, 8'h10, 3'd1, 13'h0010, 1, 0, 1, 8'd3};

    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].d);
      chk($sformatf("vec%0d.opcode", i),  32'(bus.opcode),      32'(vecs[i].opc));
      chk($sformatf("vec%0d.ir_addr", i), 32'(bus.ir_addr),     32'(vecs[i].addr));
      chk($sformatf("vec%0d.valid", i),   32'(bus.instr_valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d.phase", i),   32'(bus.byte_phase),  32'(vecs[i].ph));
      chk($sformatf("vec%0d.done", i),    32'(bus.fetch_done),  32'(vecs[i].done));
      chk($sformatf("vec%0d.cnt", i),     32'(bus.fetch_cnt),   32'(vecs[i].cnt));
    end

    // 256 back-to-back fetches from reset: done pulses on every low byte, count wraps.
    cycle(1, 1, 0, 8'h00);
    check_model("b2b_rst");
    pulses = 0;
    for (int i = 0; i < 512; i++) begin
      cycle(0, 1, 1, 8'($urandom));
      chk($sformatf("b2b%0d.done", i), 32'(bus.fetch_done), 32'(i % 2));
      check_model("b2b");
      if (bus.fetch_done === 1'b1) pulses++;
    end
    chk("b2b_pulses", 32'(pulses), 32'd256);
    chk("b2b_wrap", 32'(bus.fetch_cnt), 32'd0);

    // Idle with garbage on the data bus must not disturb anything.
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0, ($urandom_range(0, 1) == 1) ? 8'hxx : 8'($urandom));
      check_model("idle");
    end

    // Random traffic including mid-fetch resets and enable drops.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 14) != 0);
      l = ($urandom_range(0, 2) != 0);
      cycle(r, e, l, l ? 8'($urandom) : 8'hxx);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
